mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one byte-addressed 32-bit memory between two requesters of the RISC-V core: the instruction-fetch port (I, read-only word) and the load/store port (D, byte/half/word, read/write).
- Round-robin arbitration, one access per cycle, combinational grant, registered response one cycle later.
- Generates the memory byte-lane write enables, and performs load extraction and sign extension.
- Rejects misaligned accesses with an error response.

Parameters:
- ADDR_BITS, 10, byte-address width; matches the memory's address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request; held with i_addr until i_gnt.
- i_addr  input  ADDR_BITS  fetch byte address.
- i_gnt  output  1  fetch accepted this cycle (combinational).
- i_rvalid  output  1  fetch response valid (registered).
- i_rdata  output  32  fetched word (registered).
- i_err  output  1  fetch misaligned, qualified by i_rvalid.
- d_req  input  1  load/store request; held with all d_* fields until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- d_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- d_addr  input  ADDR_BITS  data byte address.
- d_wdata  input  32  store data, right-aligned.
- d_gnt  output  1  data request accepted this cycle (combinational).
- d_rvalid  output  1  data response valid (registered); asserted for loads and stores.
- d_rdata  output  32  extended load data; 0 for stores and errors.
- d_err  output  1  misaligned or illegal size, qualified by d_rvalid.
- mem_w_enb  output  4  byte-lane write enables to the memory.
- mem_r_enb  output  1  memory read enable.
- mem_addr  output  ADDR_BITS  memory byte address.
- mem_w_data  output  32  memory write data.
- mem_r_data  input  32  memory combinational read data.

Behaviour:
- Reset values:
  - All registered outputs are 0: i_rvalid, i_rdata, i_err, d_rvalid, d_rdata, d_err.
  - The priority pointer is set to D.
- Arbitration:
  - If only one port requests, that port is granted.
  - If both request, the port named by the pointer is granted.
  - After any grant, the pointer moves to the non-granted port.
  - With no request, there is no grant and the pointer holds.
  - At most one of i_gnt/d_gnt is high in any cycle.
- Memory drive:
  - Memory signals are driven combinationally from the granted request in the grant cycle.
  - With no grant, or a granted-but-faulting request: mem_w_enb = 0, mem_r_enb = 0, mem_addr = 0, mem_w_data = 0.
- Alignment:
  - I faults if i_addr[1:0] != 0.
  - D faults if d_size = 11, if half with addr[0] = 1, or if word with addr[1:0] != 0.
  - Aligned accesses never wrap past the top of memory.
- Loads:
  - Granted I access, and granted D load: mem_r_enb = 1.
  - A D load returns mem_r_data[7:0] for byte, [15:0] for half, [31:0] for word.
  - Byte and half loads are zero- or sign-extended per d_unsigned.
- Stores:
  - mem_w_enb is 0001 for byte, 0011 for half, 1111 for word.
  - mem_w_data = d_wdata; mem_r_enb = 0.
- Response:
  - Exactly one cycle after a grant, the granted port sees rvalid = 1 for one cycle, with rdata/err captured at the grant edge.
  - A faulting response has err = 1 and rdata = 0.
- Throughput:
  - A new request may be granted in the same cycle the previous response is presented; one access per cycle is sustained.
  - When both ports request continuously, grants alternate D, I, D, I, ...
- Requester rule:
  - Request fields must stay stable while req = 1 and gnt = 0.
  - Behaviour on changed fields before grant is undefined for the requester but must not corrupt memory beyond the currently driven request.
- Reset mid-operation:
  - A response scheduled for the cycle after reset is dropped (rvalid stays 0).
  - A grant in the reset cycle does not write memory: all mem_* outputs are 0 while rst = 1.
  - All gnt outputs are 0 while rst = 1.

Test Plan:
- Reset, then d_req with d_we = 1, size = 10, addr = 0x010, wdata = 0xDEADBEEF -> d_gnt = 1 and mem_w_enb = 1111 in the same cycle; d_rvalid = 1 with d_rdata = 0 the next cycle; a following word load at 0x010 returns 0xDEADBEEF.
- Byte load at 0x013 (memory byte 0xDE): d_unsigned = 0 -> d_rdata = 0xFFFFFFDE; d_unsigned = 1 -> 0x000000DE. Half load at 0x012 signed -> 0xFFFFDEAD.
- Store byte 0x55 at 0x011 -> mem_w_enb = 0001; a later word load at 0x010 returns 0xDEAD55EF.
- i_req and d_req held high for 6 cycles from reset -> grant sequence D, I, D, I, D, I; each rvalid follows its grant by exactly one cycle; i_gnt and d_gnt are never high together.
- Misaligned cases: word load at 0x012, half store at 0x011, size = 11, and i_addr = 0x002 -> gnt = 1, mem_w_enb = 0 and mem_r_enb = 0; next cycle err = 1, rdata = 0; memory contents unchanged.
- rst asserted in the cycle after a granted load -> no rvalid pulse. rst asserted together with a store request -> no gnt, mem_w_enb = 0, and the target word is unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin share of one byte-addressed 32-bit memory between
//            fetch (I) and load/store (D) ports, with alignment checking and
//            load extension.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [ADDR_BITS-1:0] i_addr,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [31:0]          i_rdata,
    output logic                 i_err,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [1:0]           d_size,
    input  logic                 d_unsigned,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [31:0]          d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [31:0]          d_rdata,
    output logic                 d_err,
    output logic [3:0]           mem_w_enb,
    output logic                 mem_r_enb,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_w_data,
    input  logic [31:0]          mem_r_data
);

    localparam logic [0:0] PRIO_I = 1'b0;
    localparam logic [0:0] PRIO_D = 1'b1;

    logic [0:0]  r_prio;
    logic        r_i_rvalid;
    logic [31:0] r_i_rdata;
    logic        r_i_err;
    logic        r_d_rvalid;
    logic [31:0] r_d_rdata;
    logic        r_d_err;

    logic        w_i_fault;
    logic        w_d_fault;
    logic        w_i_gnt;
    logic        w_d_gnt;
    logic        w_i_go;
    logic        w_d_go;
    logic [31:0] w_load;

    assign w_i_fault = |i_addr[1:0];

    always_comb begin
        w_d_fault = 1'b0;
        case (d_size)
            2'b00:   w_d_fault = 1'b0;
            2'b01:   w_d_fault = d_addr[0];
            2'b10:   w_d_fault = |d_addr[1:0];
            default: w_d_fault = 1'b1;
        endcase
    end

    // Reset suppresses grants so nothing reaches memory during reset.
    assign w_i_gnt = !rst && i_req && (!d_req || (r_prio == PRIO_I));
    assign w_d_gnt = !rst && d_req && (!i_req || (r_prio == PRIO_D));
    assign w_i_go  = w_i_gnt && !w_i_fault;
    assign w_d_go  = w_d_gnt && !w_d_fault;

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    // The memory lines up lane 0 with the addressed byte, so no lane shifting.
    always_comb begin
        mem_w_enb  = 4'b0000;
        mem_r_enb  = 1'b0;
        mem_addr   = '0;
        mem_w_data = 32'h0;
        if (w_i_go) begin
            mem_r_enb = 1'b1;
            mem_addr  = i_addr;
        end else if (w_d_go) begin
            mem_addr = d_addr;
            if (d_we) begin
                mem_w_data = d_wdata;
                case (d_size)
                    2'b00:   mem_w_enb = 4'b0001;
                    2'b01:   mem_w_enb = 4'b0011;
                    default: mem_w_enb = 4'b1111;
                endcase
            end else begin
                mem_r_enb = 1'b1;
            end
        end
    end

    always_comb begin
        w_load = mem_r_data;
        case (d_size)
            2'b00:   w_load = {{24{!d_unsigned && mem_r_data[7]}},  mem_r_data[7:0]};
            2'b01:   w_load = {{16{!d_unsigned && mem_r_data[15]}}, mem_r_data[15:0]};
            default: w_load = mem_r_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio     <= PRIO_D;
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= 32'h0;
            r_i_err    <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= 32'h0;
            r_d_err    <= 1'b0;
        end else begin
            if (w_d_gnt) begin
                r_prio <= PRIO_I;
            end else if (w_i_gnt) begin
                r_prio <= PRIO_D;
            end
            r_i_rvalid <= w_i_gnt;
            r_i_err    <= w_i_gnt && w_i_fault;
            r_i_rdata  <= w_i_go ? mem_r_data : 32'h0;
            r_d_rvalid <= w_d_gnt;
            r_d_err    <= w_d_gnt && w_d_fault;
            r_d_rdata  <= (w_d_go && !d_we) ? w_load : 32'h0;
        end
    end

    // A response due in a reset cycle is dropped rather than presented.
    assign i_rvalid = r_i_rvalid && !rst;
    assign i_rdata  = r_i_rdata;
    assign i_err    = r_i_err;
    assign d_rvalid = r_d_rvalid && !rst;
    assign d_rdata  = r_d_rdata;
    assign d_err    = r_d_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Bench for mem_arbiter: byte-array memory, rule-level reference model,
// directed scenarios with literal pins, then randomized traffic.
module tb_mem_arbiter;

    localparam int AB  = 10;
    localparam int MSZ = 1 << AB;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AB-1:0] i_addr;
    logic          i_gnt, i_rvalid, i_err;
    logic [31:0]   i_rdata;
    logic          d_req, d_we, d_unsigned;
    logic [1:0]    d_size;
    logic [AB-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt, d_rvalid, d_err;
    logic [31:0]   d_rdata;
    logic [3:0]    mem_w_enb;
    logic          mem_r_enb;
    logic [AB-1:0] mem_addr;
    logic [31:0]   mem_w_data;
    logic [31:0]   mem_r_data;

    mem_arbiter #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_w_enb(mem_w_enb), .mem_r_enb(mem_r_enb), .mem_addr(mem_addr),
        .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    // Physical memory seen by the DUT; ref_mem is the model's own copy.
    logic [7:0] phys[MSZ];
    logic [7:0] ref_mem[MSZ];

    assign mem_r_data = {phys[(int'(mem_addr) + 3) % MSZ], phys[(int'(mem_addr) + 2) % MSZ],
                         phys[(int'(mem_addr) + 1) % MSZ], phys[int'(mem_addr)]};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (mem_w_enb[k]) phys[(int'(mem_addr) + k) % MSZ] = mem_w_data[8*k +: 8];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit          prio_d = 1;
    bit          prev_rst = 1;
    bit          ev_i = 0, ee_i = 0, ev_d = 0, ee_d = 0;
    logic [31:0] ed_i = 0, ed_d = 0;
    bit          egi, egd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input int a, input int size, input bit uns);
        logic [31:0] v;
        int b0, b1, b2, b3;
        b0 = ref_mem[a]; b1 = ref_mem[(a+1)%MSZ]; b2 = ref_mem[(a+2)%MSZ]; b3 = ref_mem[(a+3)%MSZ];
        if (size == 0) begin
            v = b0;
            if (!uns && b0 >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = b1 * 256 + b0;
            if (!uns && b1 >= 128) v = v + 32'hFFFF_0000;
        end else begin
            v = (b3 << 24) + (b2 << 16) + (b1 << 8) + b0;
        end
        return v;
    endfunction

    // One clock: check last responses, check grant/memory drive, predict, clock.
    task automatic cycle();
        bit fi, fd;
        int nb;
        logic [3:0]    x_wen;
        logic          x_ren;
        logic [AB-1:0] x_addr;
        logic [31:0]   x_wdata;
        #1;
        chk("i_rvalid", {31'b0, i_rvalid}, {31'b0, ev_i && !rst});
        chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, ev_d && !rst});
        if (prev_rst || ev_i) begin
            chk("i_rdata", i_rdata, prev_rst ? 32'h0 : ed_i);
            chk("i_err", {31'b0, i_err}, {31'b0, !prev_rst && ee_i});
        end
        if (prev_rst || ev_d) begin
            chk("d_rdata", d_rdata, prev_rst ? 32'h0 : ed_d);
            chk("d_err", {31'b0, d_err}, {31'b0, !prev_rst && ee_d});
        end

        fi = i_addr[1:0] != 0;
        fd = (d_size == 3) || (d_size == 1 && d_addr[0]) || (d_size == 2 && d_addr[1:0] != 0);
        egi = 0; egd = 0;
        if (!rst) begin
            if (i_req && d_req) begin
                egd = prio_d; egi = !prio_d;
            end else begin
                egi = i_req; egd = d_req;
            end
        end
        x_wen = 0; x_ren = 0; x_addr = 0; x_wdata = 0;
        if (egi && !fi) begin
            x_ren = 1; x_addr = i_addr;
        end
        if (egd && !fd) begin
            x_addr = d_addr;
            if (d_we) begin
                nb = 1 << d_size;
                x_wen = 4'((1 << nb) - 1);
                x_wdata = d_wdata;
            end else begin
                x_ren = 1;
            end
        end
        chk("i_gnt", {31'b0, i_gnt}, {31'b0, egi});
        chk("d_gnt", {31'b0, d_gnt}, {31'b0, egd});
        chk("mem_w_enb", {28'b0, mem_w_enb}, {28'b0, x_wen});
        chk("mem_r_enb", {31'b0, mem_r_enb}, {31'b0, x_ren});
        chk("mem_addr", {22'b0, mem_addr}, {22'b0, x_addr});
        chk("mem_w_data", mem_w_data, x_wdata);

        ev_i = egi; ee_i = fi;
        ed_i = fi ? 32'h0 : model_load(int'(i_addr), 2, 1);
        ev_d = egd; ee_d = fd;
        ed_d = (fd || d_we) ? 32'h0 : model_load(int'(d_addr), int'(d_size), d_unsigned);

        @(posedge clk);
        if (egd && !fd && d_we)
            for (int k = 0; k < (1 << d_size); k++)
                ref_mem[(int'(d_addr) + k) % MSZ] = d_wdata[8*k +: 8];
        if (rst) prio_d = 1;
        else if (egd) prio_d = 0;
        else if (egi) prio_d = 1;
        prev_rst = rst;
        #1;
    endtask

    task automatic idle();
        i_req = 0; d_req = 0;
        cycle();
    endtask

    task automatic dacc(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [AB-1:0] a, input logic [31:0] wd);
        i_req = 0; d_req = 1; d_we = we; d_size = sz; d_unsigned = uns;
        d_addr = a; d_wdata = wd;
        cycle();
        d_req = 0;
    endtask

    bit          pi, pd;
    logic [31:0] snap;

    initial begin
        for (int k = 0; k < MSZ; k++) begin
            phys[k] = 8'($urandom);
            ref_mem[k] = phys[k];
        end
        rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_size = 0;
        d_unsigned = 0; d_addr = 0; d_wdata = 0;
        cycle(); cycle();
        rst = 0;
        chk("reset d_rdata", d_rdata, 32'h0);
        chk("reset i_rdata", i_rdata, 32'h0);

        // Word store then load back
        dacc(1, 2'b10, 0, 10'h010, 32'hDEADBEEF);
        chk("store resp d_rdata", d_rdata, 32'h0);
        dacc(0, 2'b10, 0, 10'h010, 0);
        chk("word load", d_rdata, 32'hDEADBEEF);
        dacc(0, 2'b00, 0, 10'h013, 0);
        chk("byte load signed", d_rdata, 32'hFFFFFFDE);
        dacc(0, 2'b00, 1, 10'h013, 0);
        chk("byte load unsigned", d_rdata, 32'h000000DE);
        dacc(0, 2'b01, 0, 10'h012, 0);
        chk("half load signed", d_rdata, 32'hFFFFDEAD);
        dacc(1, 2'b00, 0, 10'h011, 32'h00000055);
        dacc(0, 2'b10, 0, 10'h010, 0);
        chk("word after byte store", d_rdata, 32'hDEAD55EF);

        // Both ports held from reset: D, I, D, I, D, I
        rst = 1; idle(); rst = 0;
        i_req = 1; i_addr = 10'h040; d_req = 1; d_we = 0; d_size = 2'b10; d_addr = 10'h010;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("alternating d_gnt", {31'b0, d_gnt}, {31'b0, (k % 2) == 0});
            cycle();
        end
        idle();

        // Misaligned and illegal requests
        dacc(0, 2'b10, 0, 10'h012, 0);
        chk("misaligned word err", {31'b0, d_err}, 32'h1);
        chk("misaligned word rdata", d_rdata, 32'h0);
        dacc(1, 2'b01, 0, 10'h011, 32'h0000AAAA);
        chk("misaligned half store err", {31'b0, d_err}, 32'h1);
        dacc(1, 2'b11, 0, 10'h010, 32'h11111111);
        chk("illegal size err", {31'b0, d_err}, 32'h1);
        i_req = 1; i_addr = 10'h002; d_req = 0;
        cycle();
        i_req = 0;
        chk("misaligned fetch err", {31'b0, i_err}, 32'h1);
        chk("misaligned fetch rdata", i_rdata, 32'h0);
        dacc(0, 2'b10, 0, 10'h010, 0);
        chk("memory unchanged after faults", d_rdata, 32'hDEAD55EF);

        // Reset in the cycle after a granted load drops the response
        dacc(0, 2'b10, 0, 10'h010, 0);
        rst = 1;
        #1;
        chk("rvalid dropped by reset", {31'b0, d_rvalid}, 32'h0);
        cycle();
        // Store request during reset must not write
        d_req = 1; d_we = 1; d_size = 2'b10; d_addr = 10'h010; d_wdata = 32'h12345678;
        cycle();
        rst = 0;
        idle();
        dacc(0, 2'b10, 0, 10'h010, 0);
        chk("store under reset blocked", d_rdata, 32'hDEAD55EF);

        // Randomized traffic honouring the hold-until-grant rule
        pi = 0; pd = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1;
                i_addr = 10'($urandom) & (($urandom_range(0, 9) == 0) ? 10'h3FF : 10'h3FC);
            end
            if (!pd && $urandom_range(0, 1) == 1) begin
                pd = 1;
                d_we = 1'($urandom);
                d_size = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                d_unsigned = 1'($urandom);
                d_wdata = $urandom;
                d_addr = 10'($urandom) & 10'h3FC;
                if ($urandom_range(0, 9) == 0) d_addr = d_addr | 10'($urandom_range(1, 3));
                else if (d_size == 2'b00) d_addr = d_addr | 10'($urandom_range(0, 3));
                else if (d_size == 2'b01) d_addr = d_addr | 10'(2 * $urandom_range(0, 1));
            end
            i_req = pi; d_req = pd;
            cycle();
            if (egi) pi = 0;
            if (egd) pd = 0;
        end
        rst = 0;
        idle();
        idle();
        for (int k = 0; k < MSZ; k += 4) begin
            snap = {phys[k+3], phys[k+2], phys[k+1], phys[k]};
            if (k % 64 == 0)
                chk("final memory image", snap, model_load(k, 2, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
